// File: rtl/video_timing_gen.sv
// Raster timing generator: signed pixel coordinates (blanking is negative),
// sync, data-enable and line/frame start strobes.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen #(
   parameter int   COORDSPC = 16,
   parameter int   H_RES    = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_RES    = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0
) (
   input  logic                       video_clk_pix,
   input  logic                       video_rst_pix,
   output logic signed [COORDSPC-1:0] sx,
   output logic signed [COORDSPC-1:0] sy,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       video_enable,
   output logic                       line_start,
   output logic                       frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]                frame_count
`endif
);

   localparam int H_STA = -(H_FP + H_SYNC + H_BP);
   localparam int H_END = H_RES - 1;
   localparam int V_STA = -(V_FP + V_SYNC + V_BP);
   localparam int V_END = V_RES - 1;

   localparam int C_MIN = -(2 ** (COORDSPC - 1));
   localparam int C_MAX = (2 ** (COORDSPC - 1)) - 1;

   if (H_STA < C_MIN || V_STA < C_MIN || H_END > C_MAX || V_END > C_MAX) begin : g_range_err
      $fatal(1, "video_timing_gen: COORDSPC too narrow for raster coordinates");
   end

   localparam logic signed [COORDSPC-1:0] H_STA_C = COORDSPC'(H_STA);
   localparam logic signed [COORDSPC-1:0] H_END_C = COORDSPC'(H_END);
   localparam logic signed [COORDSPC-1:0] V_STA_C = COORDSPC'(V_STA);
   localparam logic signed [COORDSPC-1:0] V_END_C = COORDSPC'(V_END);
   localparam logic signed [COORDSPC-1:0] HS_BEG_C = COORDSPC'(H_STA + H_FP);
   localparam logic signed [COORDSPC-1:0] HS_END_C = COORDSPC'(H_STA + H_FP + H_SYNC - 1);
   localparam logic signed [COORDSPC-1:0] VS_BEG_C = COORDSPC'(V_STA + V_FP);
   localparam logic signed [COORDSPC-1:0] VS_END_C = COORDSPC'(V_STA + V_FP + V_SYNC - 1);
   localparam logic signed [COORDSPC-1:0] ONE_C    = COORDSPC'(1);

   logic signed [COORDSPC-1:0] sx_nxt;
   logic signed [COORDSPC-1:0] sy_nxt;
   logic                       line_end;
   logic                       hs_win;
   logic                       vs_win;
   logic                       en_nxt;
   logic                       ls_nxt;
   logic                       fs_nxt;

   // Next raster position plus every output decoded from it, so the registered
   // outputs always describe the same (sx,sy) as the counters.
   always_comb begin
      line_end = (sx == H_END_C);
      sx_nxt   = line_end ? H_STA_C : sx + ONE_C;
      sy_nxt   = sy;
      if (line_end) begin
         sy_nxt = (sy == V_END_C) ? V_STA_C : sy + ONE_C;
      end
      hs_win = (sx_nxt >= HS_BEG_C) && (sx_nxt <= HS_END_C);
      vs_win = (sy_nxt >= VS_BEG_C) && (sy_nxt <= VS_END_C);
      en_nxt = !sx_nxt[COORDSPC-1] && !sy_nxt[COORDSPC-1];
      ls_nxt = (sx_nxt == H_STA_C);
      fs_nxt = ls_nxt && (sy_nxt == V_STA_C);
   end

   // Counters and registered outputs; reset parks at the last pixel so the
   // first clock out of reset lands on a clean frame start.
   always_ff @(posedge video_clk_pix) begin
      if (video_rst_pix) begin
         sx           <= H_END_C;
         sy           <= V_END_C;
         hsync        <= !H_POL;
         vsync        <= !V_POL;
         video_enable <= 1'b0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         sx           <= sx_nxt;
         sy           <= sy_nxt;
         hsync        <= hs_win ? H_POL : !H_POL;
         vsync        <= vs_win ? V_POL : !V_POL;
         video_enable <= en_nxt;
         line_start   <= ls_nxt;
         frame_start  <= fs_nxt;
      end
   end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
   // Frame counter updates with the frame_start pulse; 0xFFFF reset makes the
   // first frame read 0.
   always_ff @(posedge video_clk_pix) begin
      if (video_rst_pix) begin
         frame_count <= 16'hFFFF;
      end else if (fs_nxt) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule
